ceespu_mem_arbiter: RTL and testbench
=====================================

# ceespu_mem_arbiter

Shares the single-ported on-chip block RAM between instruction fetch and the execute stage's load/store port. Data accesses win by default. A starvation counter guarantees fetch a slot after STARVE_LIMIT consecutive denials. Read responses are routed back to the correct requester one cycle after issue, matching the RAM's 1-cycle read latency. Sits between the fetch stage, the execute stage's O_memE/O_memWe/O_memAddress/O_StoreData outputs, and the RAM.

## Interface
- ADDR_WIDTH, 14: RAM word-address width; instruction addresses are word addresses of this width.
- STARVE_LIMIT, 4: maximum consecutive cycles fetch may be denied while requesting; range 1..15.

Ports:
- I_clk  in  1  clock; all state updates on rising edge.
- I_rst  in  1  reset, synchronous, active-high.
- I_fetchReq  in  1  fetch requests an instruction word this cycle.
- I_fetchAddr  in  ADDR_WIDTH  instruction word address.
- O_fetchStall  out  1  fetch request not granted this cycle; fetch must hold its request and address.
- O_fetchValid  out  1  O_fetchData carries the word for last cycle's granted fetch.
- O_fetchData  out  32  fetched instruction.
- I_memE  in  1  data access request from execute.
- I_memWe  in  4  byte write enables; 4'b0000 = load.
- I_memAddress  in  32  byte address.
- I_storeData  in  32  lane-replicated store data.
- O_dataStall  out  1  data access not granted this cycle; execute must hold.
- O_loadValid  out  1  O_loadData carries the word for last cycle's granted load.
- O_loadData  out  32  loaded word (full word; execute/writeback extracts lanes).
- O_dataFault  out  1  one-cycle pulse: last cycle's data address was out of range.
- O_ramEn, O_ramWe[3:0], O_ramAddr[ADDR_WIDTH-1:0], O_ramWdata[31:0]  out  RAM command.
- I_ramRdata  in  32  RAM read data; valid the cycle after O_ramEn with O_ramWe==0.

## Operation
- Data is in range iff I_memAddress[31:ADDR_WIDTH+2]==0. The RAM word address is I_memAddress[ADDR_WIDTH+1:2].
- Grant decision each cycle is combinational, evaluated in priority order:
  - I_rst high: no grant. O_ramEn=0, O_ramWe=0, both stalls 0.
  - I_fetchReq && starveCnt==STARVE_LIMIT: grant FETCH. O_dataStall=I_memE.
  - I_memE and address out of range: no RAM access (O_ramEn=0). Data is treated as granted, so O_dataStall=0. Fetch, if requesting, is granted in the same cycle.
  - I_memE in range: grant DATA. O_ramAddr from the byte address, O_ramWe=I_memWe, O_ramWdata=I_storeData. O_fetchStall=I_fetchReq.
  - I_fetchReq: grant FETCH. O_ramAddr=I_fetchAddr, O_ramWe=0.
  - Otherwise: O_ramEn=0.
- When not granted, O_ramWe=0. O_ramAddr and O_ramWdata are don't-care when O_ramEn=0.
- starveCnt (4 bits):
  - 0 when fetch is granted or I_fetchReq=0.
  - Increments, saturating at STARVE_LIMIT, when I_fetchReq=1 and fetch is denied.
- Response register lastGrant ∈ {NONE, FETCH, LOAD}, plus faultPend. Registered each cycle from that cycle's grant; DATA with nonzero I_memWe is recorded as NONE.
  - O_fetchValid = (lastGrant==FETCH).
  - O_loadValid = (lastGrant==LOAD) or faultPend.
  - O_fetchData = I_ramRdata.
  - O_loadData = faultPend ? 0 : I_ramRdata.
  - O_dataFault = faultPend.
- An out-of-range store is dropped: O_dataFault pulses and O_loadValid stays 0. To support this, faultPend is split into a load flag and a store flag.

## Timing
- Reset (synchronous): starveCnt=0, lastGrant=NONE, fault flags 0. Hence O_fetchValid, O_loadValid and O_dataFault are 0 in the cycle after the reset edge.
- Reset mid-access: a grant issued in the cycle I_rst is sampled high is suppressed. No response appears afterward.
- Latency:
  - Grant/stall: same cycle, combinational from requests.
  - Read response: exactly 1 cycle after grant.
  - Store: committed at the grant edge; no response.
- Back-to-back reads alternating requesters are allowed every cycle; responses follow in the same order.
- A stalled requester must hold its inputs stable. The arbiter has no input buffering.
- Worst-case fetch wait with continuous data traffic: STARVE_LIMIT denied cycles, then a grant.
- Worst-case data wait: 1 cycle per STARVE_LIMIT+1 cycles.
- Simultaneous fetch + out-of-range data: both are serviced in the same cycle.

## Test plan
- Reset: hold I_rst=1 with I_memE=1, I_fetchReq=1 -> O_ramEn=0. One cycle after I_rst falls, all valid/fault outputs are 0.
- Fetch only: I_fetchReq=1, I_fetchAddr=0x0010, RAM word 0x0010=0xDEADBEEF -> same cycle O_ramEn=1, O_ramAddr=0x0010, O_fetchStall=0. Next cycle O_fetchValid=1, O_fetchData=0xDEADBEEF.
- Contention: I_fetchReq=1 plus load at 0x40 for 3 cycles -> DATA granted with O_ramAddr=0x10 and O_fetchStall=1 each cycle. Each following cycle O_loadValid=1.
- Starvation, STARVE_LIMIT=4: continuous loads plus fetch -> fetch is denied 4 cycles. In the 5th cycle FETCH is granted and O_dataStall=1, then starveCnt=0 and data resumes.
- Store: I_memE=1, I_memWe=4'b0100, I_memAddress=0x22, I_storeData=0xABABABAB -> O_ramWe=4'b0100, O_ramAddr=0x08. Next cycle O_loadValid=0; read-back yields 0xAB in byte 2.
- Fault: load at 0x0001_0000 plus fetch -> O_ramEn drives the fetch, O_dataStall=0. Next cycle O_dataFault=1, O_loadValid=1, O_loadData=0, O_fetchValid=1.

Source files
------------

// File: rtl/ceespu_mem_arbiter_if.sv
// Bus bundle between the memory arbiter, the fetch/execute requesters and the block RAM.
// The arbiter takes the slave modport; the requester/RAM environment takes the master modport.
interface ceespu_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 14
);
  logic                  fetch_req;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  fetch_stall;
  logic                  fetch_valid;
  logic [31:0]           fetch_data;

  logic                  mem_e;
  logic [3:0]            mem_we;
  logic [31:0]           mem_address;
  logic [31:0]           store_data;
  logic                  data_stall;
  logic                  load_valid;
  logic [31:0]           load_data;
  logic                  data_fault;

  logic                  ram_en;
  logic [3:0]            ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [31:0]           ram_wdata;
  logic [31:0]           ram_rdata;

  modport slave (
    input  fetch_req, fetch_addr, mem_e, mem_we, mem_address, store_data, ram_rdata,
    output fetch_stall, fetch_valid, fetch_data, data_stall, load_valid, load_data,
           data_fault, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output fetch_req, fetch_addr, mem_e, mem_we, mem_address, store_data, ram_rdata,
    input  fetch_stall, fetch_valid, fetch_data, data_stall, load_valid, load_data,
           data_fault, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/ceespu_mem_arbiter.sv
// Single-port block RAM arbiter between instruction fetch and execute load/store.
// Data wins by default; a starvation counter forces a fetch slot after STARVE_LIMIT denials.
module ceespu_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  ceespu_mem_arbiter_if.slave   bus
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {G_NONE, G_FETCH, G_DATA} grant_t;
  typedef enum logic [1:0] {L_NONE, L_FETCH, L_LOAD} last_t;

  grant_t                grant;
  last_t                 last_grant;
  logic [3:0]            starve_cnt;
  logic                  fault_load;
  logic                  fault_store;
  logic                  fault_c;
  logic                  in_range;
  logic                  is_load;
  logic [ADDR_WIDTH-1:0] data_word;
  logic                  unused_addr_bits;

  assign in_range         = (bus.mem_address[31:ADDR_WIDTH+2] == '0);
  assign data_word        = bus.mem_address[ADDR_WIDTH+1:2];
  assign is_load          = (bus.mem_we == 4'b0000);
  assign unused_addr_bits = &{1'b0, bus.mem_address[1:0]};

  // Grant decision and RAM command, combinational from the current requests.
  always_comb begin
    grant           = G_NONE;
    fault_c         = 1'b0;
    bus.fetch_stall = 1'b0;
    bus.data_stall  = 1'b0;
    bus.ram_en      = 1'b0;
    bus.ram_we      = 4'b0000;
    bus.ram_addr    = bus.fetch_addr;
    bus.ram_wdata   = bus.store_data;
    if (!I_rst) begin
      if (bus.fetch_req && (starve_cnt == STARVE_MAX)) begin
        grant          = G_FETCH;
        bus.data_stall = bus.mem_e;
      end else if (bus.mem_e && !in_range) begin
        // Out-of-range data never touches the RAM, so fetch can share the cycle.
        fault_c = 1'b1;
        if (bus.fetch_req) grant = G_FETCH;
      end else if (bus.mem_e) begin
        grant           = G_DATA;
        bus.fetch_stall = bus.fetch_req;
      end else if (bus.fetch_req) begin
        grant = G_FETCH;
      end

      case (grant)
        G_FETCH: begin
          bus.ram_en   = 1'b1;
          bus.ram_addr = bus.fetch_addr;
        end
        G_DATA: begin
          bus.ram_en   = 1'b1;
          bus.ram_we   = bus.mem_we;
          bus.ram_addr = data_word;
        end
        default: ;
      endcase
    end
  end

  // Starvation counter and response routing for the 1-cycle RAM read latency.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      starve_cnt  <= 4'd0;
      last_grant  <= L_NONE;
      fault_load  <= 1'b0;
      fault_store <= 1'b0;
    end else begin
      if (!bus.fetch_req || (grant == G_FETCH)) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 4'd1;
      end

      if (grant == G_FETCH) begin
        last_grant <= L_FETCH;
      end else if ((grant == G_DATA) && is_load) begin
        last_grant <= L_LOAD;
      end else begin
        last_grant <= L_NONE;
      end

      fault_load  <= fault_c && is_load;
      fault_store <= fault_c && !is_load;
    end
  end

  assign bus.fetch_valid = (last_grant == L_FETCH);
  assign bus.fetch_data  = bus.ram_rdata;
  assign bus.load_valid  = (last_grant == L_LOAD) || fault_load;
  assign bus.load_data   = (fault_load || fault_store) ? 32'd0 : bus.ram_rdata;
  assign bus.data_fault  = fault_load || fault_store;

endmodule

// File: tb/tb_ceespu_mem_arbiter.sv
// Scoreboard bench for ceespu_mem_arbiter: directed scenarios then randomized traffic,
// with a behavioural RAM, a reference memory image and per-cycle expected responses.
module tb_ceespu_mem_arbiter;

  localparam int unsigned AW    = 14;
  localparam int unsigned SL    = 4;
  localparam int unsigned WORDS = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ceespu_mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  ceespu_mem_arbiter #(.ADDR_WIDTH(AW), .STARVE_LIMIT(SL)) dut (
    .I_clk (clk),
    .I_rst (rst),
    .bus   (bus)
  );

  // Behavioural single-port RAM with 1-cycle read latency.
  logic [31:0] ram [0:WORDS-1];
  always @(posedge clk) begin
    if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) begin
        bus.ram_rdata <= ram[bus.ram_addr];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram[bus.ram_addr][8*b +: 8] = bus.ram_wdata[8*b +: 8];
      end
    end
  end

  logic [31:0] ref_mem [0:WORDS-1];

  typedef struct { int due; logic [31:0] data; } fexp_t;
  typedef struct { int due; logic lv; logic fault; logic [31:0] data; } lexp_t;
  fexp_t fq[$];
  lexp_t lq[$];

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int starve_m   = 0;
  bit prev_fs    = 1'b0;
  bit prev_ds    = 1'b0;
  bit mon_on     = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Apply one cycle of requests (honouring hold-while-stalled), then check the grant.
  task automatic step(input bit fr, input logic [AW-1:0] fa, input bit me,
                      input logic [3:0] we, input logic [31:0] ma, input logic [31:0] sd,
                      input bit r);
    bit              in_rng, fg, dg, flt, e_fs, e_ds;
    logic [AW-1:0]   w;
    @(posedge clk);
    #1;
    rst = r;
    if (!prev_fs) begin
      bus.fetch_req  = fr;
      bus.fetch_addr = fa;
    end
    if (!prev_ds) begin
      bus.mem_e       = me;
      bus.mem_we      = we;
      bus.mem_address = ma;
      bus.store_data  = sd;
    end
    @(negedge clk);

    in_rng = (bus.mem_address >> (AW + 2)) == 32'd0;
    w      = AW'(bus.mem_address >> 2);
    fg = 0; dg = 0; flt = 0; e_fs = 0; e_ds = 0;
    if (!rst) begin
      if (bus.fetch_req && starve_m == SL) begin
        fg = 1; e_ds = bus.mem_e;
      end else if (bus.mem_e && !in_rng) begin
        flt = 1; fg = bus.fetch_req;
      end else if (bus.mem_e) begin
        dg = 1; e_fs = bus.fetch_req;
      end else begin
        fg = bus.fetch_req;
      end
    end

    chk("ram_en", 32'(bus.ram_en), 32'(fg | dg));
    chk("fetch_stall", 32'(bus.fetch_stall), 32'(e_fs));
    chk("data_stall", 32'(bus.data_stall), 32'(e_ds));
    if (fg) begin
      chk("ram_addr_fetch", 32'(bus.ram_addr), 32'(bus.fetch_addr));
      chk("ram_we_fetch", 32'(bus.ram_we), 32'd0);
      fq.push_back('{cyc + 1, ref_mem[bus.fetch_addr]});
    end else if (dg) begin
      chk("ram_addr_data", 32'(bus.ram_addr), 32'(w));
      chk("ram_we_data", 32'(bus.ram_we), 32'(bus.mem_we));
      if (bus.mem_we == 4'b0000) begin
        lq.push_back('{cyc + 1, 1'b1, 1'b0, ref_mem[w]});
      end else begin
        chk("ram_wdata", bus.ram_wdata, bus.store_data);
        for (int b = 0; b < 4; b++)
          if (bus.mem_we[b]) ref_mem[w][8*b +: 8] = bus.store_data[8*b +: 8];
      end
    end else begin
      chk("ram_we_idle", 32'(bus.ram_we), 32'd0);
    end
    if (flt) lq.push_back('{cyc + 1, bus.mem_we == 4'b0000, 1'b1, 32'd0});

    if (rst || !bus.fetch_req || fg) starve_m = 0;
    else if (starve_m < SL) starve_m++;
    prev_fs = e_fs;
    prev_ds = e_ds;
  endtask

  // Monitor: pops the response due this cycle, or requires silence.
  always @(negedge clk) begin
    if (mon_on) begin
      if (fq.size() > 0 && fq[0].due == cyc) begin
        chk("fetch_valid", 32'(bus.fetch_valid), 32'd1);
        chk("fetch_data", bus.fetch_data, fq[0].data);
        void'(fq.pop_front());
      end else begin
        chk("fetch_valid_idle", 32'(bus.fetch_valid), 32'd0);
      end
      if (lq.size() > 0 && lq[0].due == cyc) begin
        chk("load_valid", 32'(bus.load_valid), 32'(lq[0].lv));
        chk("data_fault", 32'(bus.data_fault), 32'(lq[0].fault));
        if (lq[0].lv) chk("load_data", bus.load_data, lq[0].data);
        void'(lq.pop_front());
      end else begin
        chk("load_valid_idle", 32'(bus.load_valid), 32'd0);
        chk("data_fault_idle", 32'(bus.data_fault), 32'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i]     = $urandom;
      ref_mem[i] = ram[i];
    end
    ram[16'h0010]     = 32'hDEADBEEF;
    ref_mem[16'h0010] = 32'hDEADBEEF;

    rst             = 1'b1;
    bus.fetch_req   = 1'b1;
    bus.fetch_addr  = '0;
    bus.mem_e       = 1'b1;
    bus.mem_we      = 4'b0000;
    bus.mem_address = 32'h40;
    bus.store_data  = '0;
    @(posedge clk);
    mon_on = 1'b1;

    // Reset held with both requesters active, then release.
    repeat (3) step(1, 14'h0, 1, 4'h0, 32'h40, 32'h0, 1);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Fetch only.
    step(1, 14'h0010, 0, 4'h0, 32'h0, 32'h0, 0);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Contention running into starvation.
    repeat (9) step(1, 14'h0010, 1, 4'h0, 32'h40, 32'h0, 0);
    repeat (2) step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Byte store then read-back.
    step(0, 14'h0, 1, 4'b0100, 32'h22, 32'hABABABAB, 0);
    step(0, 14'h0, 1, 4'b0000, 32'h20, 32'h0, 0);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Out-of-range load with fetch, out-of-range store alone.
    step(1, 14'h0005, 1, 4'h0, 32'h0001_0000, 32'h0, 0);
    step(0, 14'h0, 1, 4'hF, 32'h8000_0000, 32'h12345678, 0);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Reset while both requests are active.
    step(1, 14'h0011, 1, 4'h0, 32'h44, 32'h0, 0);
    step(1, 14'h0012, 1, 4'h0, 32'h48, 32'h0, 1);
    step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);

    // Randomized traffic over a small window so stores and reads collide.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ma;
      logic [3:0]  we;
      we = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
      ma = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0001_0000)
                                       : 32'($urandom_range(0, 255));
      step($urandom_range(0, 3) != 0, AW'($urandom_range(0, 63)),
           $urandom_range(0, 2) != 0, we, ma, $urandom,
           $urandom_range(0, 199) == 0);
    end

    repeat (3) step(0, 14'h0, 0, 4'h0, 32'h0, 32'h0, 0);
    chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
    chk("load_queue_drained", 32'(lq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
